// File: rtl/alu_sequencer.sv
// ALU control sequencer: decodes data-processing ops, times multi-cycle shifts/MUL, owns flags.
// Optional MUL support is enabled by defining ALU_SEQ_MUL_EN.
module alu_sequencer #(
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned SHAMT_W    = 5,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [3:0]         alu_flags,
  output logic [CTRL_W-1:0]  alu_control,
  output logic [1:0]         flag_w,
  output logic               step,
  output logic               out_valid,
  output logic [3:0]         flags
);

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CntW = (SHAMT_W > 4) ? SHAMT_W : 4;
`else
  localparam int unsigned CntW = SHAMT_W;
`endif

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_code;
  logic [1:0]        r_flag_w;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [3:0]        r_flags;

  logic [3:0]        w_code;
  logic [1:0]        w_fl;
  logic [1:0]        w_fw;
  logic              w_shift;
  logic              w_accept;
  logic              w_unused_funct5;
`ifdef ALU_SEQ_MUL_EN
  logic              w_mul;
`endif

  assign w_unused_funct5 = funct[5];
  assign w_accept        = in_valid & in_ready;

  always_comb begin
    w_code  = 4'b0000;
    w_fl    = 2'b00;
    w_shift = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_mul   = 1'b0;
`endif
    if (alu_op) begin
      case (funct[4:1])
        4'b0000: begin w_code = 4'b1000; w_fl = 2'b10; end
        4'b1100: begin w_code = 4'b1001; w_fl = 2'b10; end
        4'b1101: begin w_code = 4'b1011; w_fl = 2'b10; w_shift = 1'b1; end
        4'b1110: begin w_code = 4'b1100; w_fl = 2'b10; w_shift = 1'b1; end
        4'b0100: begin w_code = 4'b0000; w_fl = 2'b11; end
        4'b0010: begin w_code = 4'b0001; w_fl = 2'b11; end
`ifdef ALU_SEQ_MUL_EN
        4'b1001: begin w_code = 4'b1010; w_fl = 2'b10; w_mul = 1'b1; end
`endif
        default: ;
      endcase
    end
    w_fw = funct[0] ? w_fl : 2'b00;
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (w_mul) begin
            w_state_d = StExec;
            w_cnt_d   = CntW'(MUL_CYCLES);
          end else
`endif
          if (w_shift && (shamt != '0)) begin
            w_state_d = StExec;
            w_cnt_d   = CntW'(shamt);
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StExec: begin
        if (r_cnt == CntW'(1)) begin
          w_state_d = StDone;
        end
        w_cnt_d = r_cnt - CntW'(1);
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_code   <= 4'b0000;
      r_flag_w <= 2'b00;
      r_flags  <= 4'b0000;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_code   <= w_code;
        r_flag_w <= w_fw;
      end else if (r_state == StDone) begin
        r_code   <= 4'b0000;
        r_flag_w <= 2'b00;
      end
      // Flags commit on the edge that closes DONE; unselected pairs hold.
      if (r_state == StDone) begin
        if (r_flag_w[1]) r_flags[3:2] <= alu_flags[3:2];
        if (r_flag_w[0]) r_flags[1:0] <= alu_flags[1:0];
      end
    end
  end

  assign in_ready    = (r_state == StIdle);
  assign alu_control = CTRL_W'(r_code);
  assign flag_w      = (r_state == StDone) ? r_flag_w : 2'b00;
  assign step        = (r_state == StExec);
  assign out_valid   = (r_state == StDone);
  assign flags       = r_flags;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter CTRL_W, default 4, SHALL set the alu_control width; codes occupy bits [3:0] and upper bits are zero.
REQ-002 Parameter SHAMT_W, default 5, SHALL set the shift-count width; maximum iterative shift is 2^SHAMT_W-1.
REQ-003 Parameter MUL_CYCLES, default 4, range 1..15, SHALL set the MUL execution length in cycles.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  a new operation is presented.
REQ-007 in_ready  output  1  the block accepts an operation this cycle.
REQ-008 alu_op  input  1  1 = data-processing decode; 0 = pass-through ADD with no flag writes.
REQ-009 funct  input  6  funct[4:1] = operation, funct[0] = S (set-flags) bit.
REQ-010 shamt  input  SHAMT_W  shift count for LSL/LSR.
REQ-011 alu_flags  input  4  {N,Z,C,V} produced by the datapath ALU this cycle.
REQ-012 alu_control  output  CTRL_W  registered ALU operation code.
REQ-013 flag_w  output  2  [1] = write N,Z; [0] = write C,V; valid while out_valid is high.
REQ-014 step  output  1  the datapath performs one iteration (shift-by-1 or MUL step) this cycle.
REQ-015 out_valid  output  1  one-cycle pulse marking operation completion.
REQ-016 flags  output  4  registered {N,Z,C,V}.

Function
REQ-017 Decode of funct[4:1] SHALL be as follows (code/flags when S=1; flag_w SHALL be 00 when S=0):
- 0000 AND: code 1000, flags 10
- 1100 ORR: code 1001, flags 10
- 1101 LSL: code 1011, flags 10
- 1110 LSR: code 1100, flags 10
- 0100 ADD: code 0000, flags 11
- 0010 SUB: code 0001, flags 11
- 1001 MUL: code 1010, flags 10
- any other value: code 0000, flags 00
REQ-018 When alu_op=0, the decode SHALL be code 0000 with flag_w 00 regardless of funct.
REQ-019 The FSM SHALL have states IDLE, EXEC, DONE; in_ready SHALL equal (state==IDLE).
REQ-020 Accept condition: in_valid & in_ready; the block SHALL latch the decoded code, flag_w, and shamt on acceptance.
REQ-021 AND, ORR, ADD, SUB, unknown operations, and alu_op=0 operations SHALL go IDLE->DONE; out_valid SHALL assert the cycle after acceptance (latency 1); step SHALL stay 0.
REQ-022 LSL/LSR with shamt=N>0 SHALL go IDLE->EXEC, assert step for exactly N consecutive cycles, then enter DONE; out_valid SHALL assert N+1 cycles after acceptance.
REQ-023 LSL/LSR with shamt=0 SHALL behave as a single-cycle operation with no step pulse.
REQ-024 MUL SHALL remain in EXEC with step high for MUL_CYCLES cycles, then enter DONE.
REQ-025 DONE SHALL last one cycle and then return to IDLE; in_valid during EXEC or DONE SHALL be ignored.
REQ-026 alu_control SHALL hold the latched code from acceptance through DONE, and 0 in IDLE.
REQ-027 At the clock edge ending DONE, the block SHALL update flags[3:2] from alu_flags[3:2] if flag_w[1], and flags[1:0] from alu_flags[1:0] if flag_w[0]; unselected bits SHALL hold.
REQ-028 out_valid has no backpressure; the consumer SHALL sample results in the DONE cycle.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE and alu_control=0, flag_w=00, step=0, out_valid=0, flags=0000; in_ready SHALL be 1 after reset deasserts.
REQ-030 Reset during EXEC or DONE SHALL abort the operation without an out_valid pulse or flag update.

Configuration
REQ-031 Macro ALU_SEQ_MUL_EN defined: MUL decode and the MUL_CYCLES sequencing SHALL be present.
REQ-032 Macro ALU_SEQ_MUL_EN undefined: funct[4:1]=1001 SHALL decode as an unknown operation (code 0000, flags 00, latency 1); no MUL counter logic SHALL be present.

Verification
REQ-033 ADD with S=1 (funct=001001), alu_flags=0110: expect out_valid in cycle +1, alu_control=0000, flag_w=11, flags=0110 afterwards.
REQ-034 flags=1111, then AND with S=1 (funct=000001), alu_flags=0000: expect flags=0011 (C,V held).
REQ-035 LSL with shamt=3: expect step high for 3 cycles, out_valid at cycle +4, code 1011; a second in_valid during EXEC is ignored.
REQ-036 LSR with shamt=0: expect out_valid at cycle +1 and no step pulse.
REQ-037 With ALU_SEQ_MUL_EN defined and MUL_CYCLES=4, MUL with S=1: expect 4 step cycles, out_valid at +5, code 1010. With the macro undefined: expect out_valid at +1, code 0000, flag_w 00.
REQ-038 Reset asserted on the 2nd step of LSL shamt=5: expect immediate IDLE, no out_valid, flags=0000.
